// File: rtl/stream_frame_arbiter.sv
// stream_frame_arbiter: merges two AXI4-Stream video sources into a single
// registered output slice. Ownership changes only at frame boundaries
// (line-count based) and alternates round-robin between the sources.
// Optional build macro FRAME_TIMEOUT_EN: adds the TIMEOUT parameter, a
// watchdog on the granted source and the timeout_err pulse output.
module stream_frame_arbiter #(
    parameter int DATA_W     = 24,
    parameter int LINE_CNT_W = 12
`ifdef FRAME_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 65535
`endif
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [LINE_CNT_W-1:0] frame_lines,
    input  logic [DATA_W-1:0]     s0_tdata,
    input  logic [7:0]            s0_tuser,
    input  logic                  s0_tlast,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_W-1:0]     s1_tdata,
    input  logic [7:0]            s1_tuser,
    input  logic                  s1_tlast,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    output logic [DATA_W-1:0]     m_tdata,
    output logic [7:0]            m_tuser,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [1:0]            grant,
    output logic                  frame_done,
    output logic [15:0]           drop_cnt
`ifdef FRAME_TIMEOUT_EN
    ,
    output logic                  timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;
    logic [LINE_CNT_W-1:0] lines_lat_q, lines_lat_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic                  m_tvalid_q, m_tvalid_d;
    logic [DATA_W-1:0]     m_tdata_q, m_tdata_d;
    logic [7:0]            m_tuser_q, m_tuser_d;
    logic                  m_tlast_q, m_tlast_d;
    logic                  frame_done_q, frame_done_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;
`ifdef FRAME_TIMEOUT_EN
    logic [15:0]           wdog_q, wdog_d;
    logic                  timeout_err_q, timeout_err_d;
`endif

    logic                  sof0, sof1, drop0, drop1;
    logic                  slice_free;
    logic                  src_valid, src_last;
    logic [DATA_W-1:0]     src_data;
    logic [7:0]            src_user;
    logic                  accept;
    logic                  last_line;

    // Adds 0..2 dropped beats to the counter, pinning at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign sof0  = s0_tvalid && s0_tuser[0];
    assign sof1  = s1_tvalid && s1_tuser[0];
    assign drop0 = s0_tvalid && !s0_tuser[0];
    assign drop1 = s1_tvalid && !s1_tuser[0];

    // The slice can take a beat when empty or when its content leaves this cycle.
    assign slice_free = !m_tvalid_q || m_tready;

    // Granted-source view; only meaningful in GNT0/GNT1.
    assign src_valid = (state_q == GNT1) ? s1_tvalid : s0_tvalid;
    assign src_last  = (state_q == GNT1) ? s1_tlast  : s0_tlast;
    assign src_data  = (state_q == GNT1) ? s1_tdata  : s0_tdata;
    assign src_user  = (state_q == GNT1) ? s1_tuser  : s0_tuser;
    assign accept    = (state_q != IDLE) && src_valid && slice_free;
    assign last_line = (line_cnt_q == lines_lat_q - LINE_CNT_W'(1));

    // While idle, non-SOF beats are swallowed to resync a source; SOF beats wait.
    assign s0_tready = (state_q == IDLE) ? !s0_tuser[0] : ((state_q == GNT0) && slice_free);
    assign s1_tready = (state_q == IDLE) ? !s1_tuser[0] : ((state_q == GNT1) && slice_free);

    assign m_tdata    = m_tdata_q;
    assign m_tuser    = m_tuser_q;
    assign m_tlast    = m_tlast_q;
    assign m_tvalid   = m_tvalid_q;
    assign grant      = {state_q == GNT1, state_q == GNT0};
    assign frame_done = frame_done_q;
    assign drop_cnt   = drop_cnt_q;
`ifdef FRAME_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`endif

    // Next-state: grant decision, frame line counting and output slice loading.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        lines_lat_d  = lines_lat_q;
        line_cnt_d   = line_cnt_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        m_tuser_d    = m_tuser_q;
        m_tlast_d    = m_tlast_q;
        frame_done_d = 1'b0;
        drop_cnt_d   = drop_cnt_q;
`ifdef FRAME_TIMEOUT_EN
        wdog_d        = wdog_q;
        timeout_err_d = 1'b0;
`endif
        if (state_q == IDLE) begin
            drop_cnt_d = sat_add16(drop_cnt_q, {1'b0, drop0} + {1'b0, drop1});
            // A frame's last beat may still be draining after the grant ended.
            if (m_tvalid_q && m_tready) begin
                m_tvalid_d = 1'b0;
            end
            if (sof0 || sof1) begin
                // ptr_q == 0 favours source 0 on a tie.
                state_d     = (sof0 && (!sof1 || !ptr_q)) ? GNT0 : GNT1;
                lines_lat_d = (frame_lines == '0) ? LINE_CNT_W'(1) : frame_lines;
                line_cnt_d  = '0;
`ifdef FRAME_TIMEOUT_EN
                wdog_d      = '0;
`endif
            end
        end else begin
            if (accept) begin
                m_tvalid_d = 1'b1;
                m_tdata_d  = src_data;
                m_tuser_d  = src_user;
                m_tlast_d  = src_last;
                if (src_last) begin
                    if (last_line) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                        ptr_d        = (state_q == GNT0);
                    end else begin
                        line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
                    end
                end
            end else if (m_tvalid_q && m_tready) begin
                m_tvalid_d = 1'b0;
            end
`ifdef FRAME_TIMEOUT_EN
            // Only source starvation advances the watchdog; backpressure does not.
            if (accept) begin
                wdog_d = '0;
            end else if (!src_valid) begin
                if (wdog_q == 16'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                    ptr_d         = (state_q == GNT0);
                    wdog_d        = '0;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
            end
`endif
        end
    end

    // State and output slice registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            ptr_q        <= 1'b0;
            lines_lat_q  <= LINE_CNT_W'(1);
            line_cnt_q   <= '0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tuser_q    <= '0;
            m_tlast_q    <= 1'b0;
            frame_done_q <= 1'b0;
            drop_cnt_q   <= '0;
`ifdef FRAME_TIMEOUT_EN
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lines_lat_q  <= lines_lat_d;
            line_cnt_q   <= line_cnt_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tuser_q    <= m_tuser_d;
            m_tlast_q    <= m_tlast_d;
            frame_done_q <= frame_done_d;
            drop_cnt_q   <= drop_cnt_d;
`ifdef FRAME_TIMEOUT_EN
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_stream_frame_arbiter.sv
// Bench for stream_frame_arbiter: frame-level reference model, per-cycle
// comparison, directed scenarios with literal expectations, random traffic.
module tb_stream_frame_arbiter;

    localparam int DW = 24;
    localparam int LW = 12;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          resetn;
    logic [LW-1:0] frame_lines;
    logic [DW-1:0] s0_tdata, s1_tdata, m_tdata;
    logic [7:0]    s0_tuser, s1_tuser, m_tuser;
    logic          s0_tlast, s1_tlast, m_tlast;
    logic          s0_tvalid, s1_tvalid, m_tvalid;
    logic          s0_tready, s1_tready, m_tready;
    logic [1:0]    grant;
    logic          frame_done;
    logic [15:0]   drop_cnt;
`ifdef FRAME_TIMEOUT_EN
    logic          timeout_err;
`endif

    stream_frame_arbiter #(.DATA_W(DW), .LINE_CNT_W(LW)) dut (
        .clk(clk), .resetn(resetn), .frame_lines(frame_lines),
        .s0_tdata(s0_tdata), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .grant(grant), .frame_done(frame_done),
`ifdef FRAME_TIMEOUT_EN
        .timeout_err(timeout_err),
`endif
        .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [23:0] d;
        logic [7:0]  u;
        logic        l;
    } beat_t;

    beat_t q0[$], q1[$];
    beat_t obs[$];
    logic [1:0] glog[$];
    bit    rpat[$];

    int n_cmp = 0, n_bad = 0;

    // Reference model: owner -1 = nobody, lines counted up to the latched target.
    int          owner, ptr, tgt, seen, drops;
    logic        mv, ml, mfd;
    logic [23:0] md;
    logic [7:0]  mu;
    bit          acc0, acc1;

    int          vprob, rprob;
    bit          rst_req, flush, fl_rand, chk_rst;
    logic [LW-1:0] fl_fixed;
    logic [1:0]  last_grant;
    int          n_fd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1; ptr = 0; tgt = 1; seen = 0; drops = 0;
        mv = 1'b0; md = '0; mu = '0; ml = 1'b0; mfd = 1'b0;
    endtask

    function automatic logic [1:0] exp_grant();
        if (owner < 0) return 2'b00;
        return (owner == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic push_frame(input int src, input int lines, input int bpl, input int base);
        beat_t b;
        int k = 0;
        for (int l = 0; l < lines; l++) begin
            for (int x = 0; x < bpl; x++) begin
                b.d = 24'(base + k);
                b.u = {7'($urandom), (k == 0)};
                b.l = (x == bpl - 1);
                if (src == 0) q0.push_back(b); else q1.push_back(b);
                k++;
            end
        end
    endtask

    task automatic push_junk(input int src, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.d = 24'($urandom);
            b.u = {7'($urandom), 1'b0};
            b.l = 1'($urandom);
            if (src == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    // One clock: compare registered outputs, drive inputs, compare tready, advance model.
    task automatic cycle();
        bit r0, r1, a, s0f, s1f;
        beat_t b;
        @(negedge clk);
        chk("m_tvalid", 32'(m_tvalid), 32'(mv));
        if (mv) begin
            chk("m_tdata", 32'(m_tdata), 32'(md));
            chk("m_tuser", 32'(m_tuser), 32'(mu));
            chk("m_tlast", 32'(m_tlast), 32'(ml));
        end
        chk("grant", 32'(grant), 32'(exp_grant()));
        chk("frame_done", 32'(frame_done), 32'(mfd));
        chk("drop_cnt", 32'(drop_cnt), 32'(drops));
        if (chk_rst) begin
            chk_rst = 1'b0;
            chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
            chk("rst_m_tdata", 32'(m_tdata), 32'd0);
            chk("rst_m_tuser", 32'(m_tuser), 32'd0);
            chk("rst_m_tlast", 32'(m_tlast), 32'd0);
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_frame_done", 32'(frame_done), 32'd0);
            chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        end
        if (frame_done) n_fd++;
        if (grant != 2'b00 && grant != last_grant) glog.push_back(grant);
        last_grant = grant;
        if (m_tvalid && m_tready && resetn) begin
            b.d = m_tdata; b.u = m_tuser; b.l = m_tlast;
            obs.push_back(b);
        end

        if (acc0) void'(q0.pop_front());
        if (acc1) void'(q1.pop_front());
        if (flush || !(s0_tvalid && !acc0)) begin
            if (!flush && q0.size() > 0 && $urandom_range(99) < vprob) begin
                s0_tvalid = 1'b1; {s0_tdata, s0_tuser, s0_tlast} = q0[0];
            end else begin
                s0_tvalid = 1'b0; s0_tdata = 24'($urandom); s0_tuser = 8'($urandom); s0_tlast = 1'($urandom);
            end
        end
        if (flush || !(s1_tvalid && !acc1)) begin
            if (!flush && q1.size() > 0 && $urandom_range(99) < vprob) begin
                s1_tvalid = 1'b1; {s1_tdata, s1_tuser, s1_tlast} = q1[0];
            end else begin
                s1_tvalid = 1'b0; s1_tdata = 24'($urandom); s1_tuser = 8'($urandom); s1_tlast = 1'($urandom);
            end
        end
        if (rpat.size() > 0) m_tready = rpat.pop_front();
        else                 m_tready = ($urandom_range(99) < rprob);
        resetn      = !rst_req;
        frame_lines = fl_rand ? LW'($urandom_range(3)) : fl_fixed;

        #1;
        r0 = 1'b0; r1 = 1'b0;
        if (owner < 0) begin
            r0 = !s0_tuser[0];
            r1 = !s1_tuser[0];
        end else if (owner == 0) begin
            r0 = !mv || m_tready;
        end else begin
            r1 = !mv || m_tready;
        end
        if (resetn) begin
            chk("s0_tready", 32'(s0_tready), 32'(r0));
            chk("s1_tready", 32'(s1_tready), 32'(r1));
        end
        acc0 = resetn && s0_tvalid && r0;
        acc1 = resetn && s1_tvalid && r1;

        if (!resetn) begin
            model_reset();
        end else begin
            mfd = 1'b0;
            if (owner < 0) begin
                if (acc0) drops = (drops < 65535) ? drops + 1 : 65535;
                if (acc1) drops = (drops < 65535) ? drops + 1 : 65535;
                if (mv && m_tready) mv = 1'b0;
                s0f = s0_tvalid && s0_tuser[0];
                s1f = s1_tvalid && s1_tuser[0];
                if (s0f || s1f) begin
                    owner = (s0f && s1f) ? ptr : (s0f ? 0 : 1);
                    tgt   = (frame_lines == 0) ? 1 : int'(frame_lines);
                    seen  = 0;
                end
            end else begin
                a = (owner == 0) ? acc0 : acc1;
                if (a) begin
                    mv = 1'b1;
                    md = (owner == 0) ? s0_tdata : s1_tdata;
                    mu = (owner == 0) ? s0_tuser : s1_tuser;
                    ml = (owner == 0) ? s0_tlast : s1_tlast;
                    if (ml) begin
                        seen++;
                        if (seen == tgt) begin
                            mfd = 1'b1; ptr = 1 - owner; owner = -1;
                        end
                    end
                end else if (mv && m_tready) begin
                    mv = 1'b0;
                end
            end
        end
    endtask

    task automatic clear_obs();
        obs.delete(); glog.delete(); n_fd = 0;
    endtask

    // Two-cycle reset that also withdraws and discards all pending source traffic.
    task automatic do_reset();
        q0.delete(); q1.delete(); rpat.delete();
        rst_req = 1'b1; flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        rst_req = 1'b0; chk_rst = 1'b1;
        clear_obs();
    endtask

    initial begin
        int rem;
        resetn = 1'b0; frame_lines = '0; m_tready = 1'b0;
        s0_tvalid = 1'b0; s0_tdata = '0; s0_tuser = '0; s0_tlast = 1'b0;
        s1_tvalid = 1'b0; s1_tdata = '0; s1_tuser = '0; s1_tlast = 1'b0;
        acc0 = 0; acc1 = 0; rst_req = 0; flush = 0; chk_rst = 0;
        fl_rand = 0; fl_fixed = LW'(2); vprob = 100; rprob = 100;
        last_grant = 2'b00; n_fd = 0;
        model_reset();
        @(posedge clk);

        // Single 2-line frame from source 0.
        do_reset();
        fl_fixed = LW'(2);
        push_frame(0, 2, 4, 'h100);
        repeat (20) cycle();
        chk("t1_beats", 32'(obs.size()), 32'd8);
        for (int k = 0; k < obs.size() && k < 8; k++) begin
            chk("t1_data", 32'(obs[k].d), 32'(24'h100 + k));
            chk("t1_last", 32'(obs[k].l), 32'((k == 3) || (k == 7)));
        end
        chk("t1_fd_count", 32'(n_fd), 32'd1);
        chk("t1_grants", 32'(glog.size()), 32'd1);
        if (glog.size() > 0) chk("t1_grant", 32'(glog[0]), 32'd1);
        chk("t1_final_grant", 32'(grant), 32'd0);

        // Simultaneous SOF: round-robin order s0, s1, s0.
        do_reset();
        fl_fixed = LW'(1);
        push_frame(0, 1, 3, 'h200);
        push_frame(0, 1, 3, 'h210);
        push_frame(1, 1, 3, 'h300);
        repeat (30) cycle();
        chk("t2_grants", 32'(glog.size()), 32'd3);
        for (int k = 0; k < glog.size() && k < 3; k++)
            chk("t2_grant_order", 32'(glog[k]), (k == 1) ? 32'd2 : 32'd1);
        chk("t2_fd_count", 32'(n_fd), 32'd3);
        chk("t2_beats", 32'(obs.size()), 32'd9);
        if (obs.size() >= 9) begin
            chk("t2_s1_first", 32'(obs[3].d), 32'h300);
            chk("t2_s0_second", 32'(obs[6].d), 32'h210);
        end

        // Idle resync: three non-SOF beats dropped, then SOF granted.
        do_reset();
        push_junk(1, 3);
        push_frame(1, 1, 2, 'h400);
        repeat (15) cycle();
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd3);
        chk("t3_grants", 32'(glog.size()), 32'd1);
        if (glog.size() > 0) chk("t3_grant", 32'(glog[0]), 32'd2);
        chk("t3_beats", 32'(obs.size()), 32'd2);
        if (obs.size() > 0) chk("t3_first_sof", 32'(obs[0].u[0]), 32'd1);

        // Downstream stalls: no loss, no duplication.
        do_reset();
        push_frame(0, 1, 6, 'h500);
        rpat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        repeat (25) cycle();
        chk("t4_beats", 32'(obs.size()), 32'd6);
        for (int k = 0; k < obs.size() && k < 6; k++)
            chk("t4_data", 32'(obs[k].d), 32'(24'h500 + k));

        // Reset in the middle of a granted frame.
        do_reset();
        fl_fixed = LW'(2);
        push_frame(0, 2, 4, 'h600);
        for (int k = 0; k < 40 && obs.size() < 3; k++) cycle();
        chk("t5_progress", 32'(obs.size() >= 3), 32'd1);
        rst_req = 1'b1;
        cycle();
        rst_req = 1'b0; chk_rst = 1'b1;
        rem = q0.size();
        clear_obs();
        repeat (20) cycle();
        chk("t5_drop_cnt", 32'(drop_cnt), 32'(rem));
        chk("t5_grant_idle", 32'(grant), 32'd0);
        chk("t5_no_output", 32'(obs.size()), 32'd0);
        push_frame(1, 1, 2, 'h700);
        repeat (10) cycle();
        chk("t5_regrant", 32'(glog.size()), 32'd1);
        if (glog.size() > 0) chk("t5_regrant_s1", 32'(glog[0]), 32'd2);

        // Saturation of the drop counter.
        do_reset();
        push_junk(0, 33000);
        push_junk(1, 33000);
        repeat (32900) cycle();
        chk("t6_drop_sat", 32'(drop_cnt), 32'hFFFF);

        // Random traffic, random frame_lines, random backpressure, rare resets.
        do_reset();
        fl_rand = 1'b1; vprob = 75; rprob = 70;
        for (int c = 0; c < 5000; c++) begin
            if (q0.size() < 8) begin
                if ($urandom_range(7) == 0) push_junk(0, $urandom_range(3, 1));
                else push_frame(0, $urandom_range(3, 1), $urandom_range(4, 1), int'($urandom_range(16'hFFFF)));
            end
            if (q1.size() < 8) begin
                if ($urandom_range(7) == 0) push_junk(1, $urandom_range(3, 1));
                else push_frame(1, $urandom_range(3, 1), $urandom_range(4, 1), int'($urandom_range(16'hFFFF)) + 'h10000);
            end
            rst_req = ($urandom_range(1499) == 0);
            cycle();
        end
        rst_req = 1'b0;
        repeat (3) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_frame_arbiter.md
Name: stream_frame_arbiter

Overview:
- Shares one downstream video pipeline between two AXI4-Stream video sources.
- Each source delivers frames marked with tuser[0] as start-of-frame (SOF) and tlast as end-of-line (EOL).
- The grant changes only at frame boundaries, using round-robin between the two sources.
- The merged stream leaves through a one-stage registered output slice that feeds the sideband delay registers and the kernels that follow.

Parameters:
- DATA_W, 24, pixel data width.
- LINE_CNT_W, 12, width of the line counter and of the frame_lines input.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- frame_lines  in  LINE_CNT_W  lines per frame; sampled at grant.
- s0_tdata  in  DATA_W  source 0 pixel.
- s0_tuser  in  8  source 0 sideband; bit 0 = SOF.
- s0_tlast  in  1  source 0 EOL.
- s0_tvalid  in  1  source 0 valid.
- s0_tready  out  1  source 0 ready.
- s1_tdata, s1_tuser, s1_tlast, s1_tvalid, s1_tready  same as the s0 ports, for source 1.
- m_tdata  out  DATA_W  merged pixel.
- m_tuser  out  8  merged sideband.
- m_tlast  out  1  merged EOL.
- m_tvalid  out  1  merged valid.
- m_tready  in  1  downstream ready.
- grant  out  2  one-hot active source; 00 when idle.
- frame_done  out  1  one-cycle pulse when a frame's final beat is accepted.
- drop_cnt  out  16  saturating count of beats discarded while idle.

Behaviour:
- Reset (resetn=0 at a clk edge):
  - state=IDLE, grant=00, priority pointer=source 0.
  - m_tvalid=0; m_tdata, m_tuser, m_tlast = 0.
  - frame_done=0, drop_cnt=0, line counter=0.
  - Reset mid-frame abandons the frame; the output register is cleared and nothing partial is flushed.
- States: IDLE, GNT0, GNT1.
- IDLE:
  - A source with tvalid=1 and tuser[0]=0 gets tready=1; its beat is dropped and drop_cnt increments, saturating at 0xFFFF. This resynchronises a source that is mid-frame.
  - A source with tvalid=1 and tuser[0]=1 gets tready=0; its beat is held.
  - If exactly one source holds SOF, go to GNTx on the next edge.
  - If both hold SOF, grant the source named by the priority pointer.
  - On grant: latch lines_lat = max(frame_lines, 1) and clear the line counter.
  - No beat is accepted in the IDLE cycle in which the grant is decided.
- GNTx:
  - sx_tready = (!m_tvalid || m_tready). The other source's tready = 0.
  - Accepted beat (sx_tvalid && sx_tready) loads the output register on the next edge, so latency is 1 cycle.
  - If m_tvalid && m_tready with no new beat accepted, m_tvalid clears.
  - Accepted beat with tlast=1 increments the line counter.
  - When the line counter equals lines_lat-1 on an accepted tlast beat:
    - frame_done pulses in the following cycle;
    - state returns to IDLE;
    - the pointer moves to the other source.
- Output slice:
  - Full throughput: one beat per cycle while m_tready=1.
  - m_* fields are held stable while m_tvalid && !m_tready.
  - The final beat of a frame may still be sitting in the output register while the state is already IDLE. It drains normally.
  - A new grant may be issued from IDLE regardless, but its beats are only accepted when the slice can take them.
- SOF inside a granted frame is passed through unchanged. Frame termination is by line count only.
- frame_lines changes take effect at the next grant only.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- When defined:
  - Adds parameter TIMEOUT (default 65535) and output port timeout_err (out, 1).
  - A 16-bit watchdog counts cycles in GNTx in which the granted source is not valid (sx_tvalid=0); it resets on every accepted beat.
  - Stall cycles where sx_tvalid=1 but m_tready=0 (downstream backpressure) do not advance the watchdog.
  - On reaching TIMEOUT: pulse timeout_err for one cycle, return to IDLE, toggle the pointer, and do not pulse frame_done.
  - The output register drains normally.
- When undefined: no watchdog, no timeout_err port, and the grant is held indefinitely.

Test Plan:
- frame_lines=2. s0 sends an 8-beat frame (4 beats per line, tlast on beats 4 and 8, tuser[0]=1 on beat 1); m_tready=1 -> grant=01; m_* match the inputs 1 cycle later; frame_done pulses once after beat 8; grant=00.
- Both sources present SOF in the same cycle after reset -> s0 is granted first; after s0's frame completes, s1 is granted; s0's next SOF waits until s1's frame_done.
- s1 sends 3 non-SOF beats and then SOF while idle -> drop_cnt=3; s1 is granted; first m_tuser[0]=1.
- Granted frame with m_tready toggling 1,0,0,1 -> no beat lost or duplicated; m_* held during the stall; s0_tready=0 while the output register is full.
- resetn=0 for one cycle mid-frame -> all outputs reset as above next cycle; the remaining beats of that frame are dropped (drop_cnt increments) until the next SOF.
- FRAME_TIMEOUT_EN, TIMEOUT=16: s0 stalls with tvalid=0 for 16 cycles mid-frame -> timeout_err pulses; state is IDLE; a waiting s1 SOF is granted next.
